serial_add_ctrl: RTL and testbench

Sequencer that performs one N-bit addition or subtraction by driving a single 4-bit ripple adder (`add4`) for N/4 consecutive cycles, least-significant nibble first. Carry is held in a register between nibbles. It is the multi-word front end for the lab-4 adder datapath: the host supplies wide operands with a start pulse, and the block returns the sum, carry-out and signed overflow with a one-cycle done pulse.

---
 rtl/serial_add_ctrl_pkg.sv | 19 +
 rtl/serial_add_ctrl_add4.sv | 22 ++
 rtl/serial_add_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
package serial_add_ctrl_pkg;

    // Sequencer states; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Width of one datapath slice.
    localparam int NIBBLE_W = 4;

    // Counter width: ceil(log2(nib)), never below one bit.
    function automatic int cnt_width(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_add4.sv
// 4-bit ripple-carry adder used as the nibble datapath of serial_add_ctrl.
module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    // Four full adders chained through c[].
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-word add/sub front end: runs one N-bit operation through a single
// add4 slice over NIB cycles, LS nibble first, carry held between nibbles.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int N   = 16,
    parameter int NIB = N / 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] so,
    output logic         co,
    output logic         ovf
);

    localparam int CW = cnt_width(NIB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    a_sh_q, a_sh_d;
    logic [N-1:0]    b_sh_q, b_sh_d;
    logic [N-1:0]    r_sh_q, r_sh_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    so_q, so_d;
    logic            co_q, co_d;
    logic            ovf_q, ovf_d;

    logic [3:0]      nib_sum;
    logic            nib_co;
    logic            msb_cin;
    logic [N+3:0]    r_cat;
    logic [N-1:0]    r_next;

    // Nibble datapath: always fed from the low nibble of the operand shifters.
    add4 u_add4 (
        .a  (a_sh_q[3:0]),
        .b  (b_sh_q[3:0]),
        .ci (carry_q),
        .s  (nib_sum),
        .co (nib_co)
    );

    // Result shifter input: new nibble enters at the top. Concatenating
    // before the shift keeps this valid for N=4, where there is no old part.
    assign r_cat  = {nib_sum, r_sh_q};
    assign r_next = r_cat[N+3:4];

    // Carry into the sign bit, recovered from the last slice's sum bit.
    assign msb_cin = a_sh_q[3] ^ b_sh_q[3] ^ nib_sum[3];

    // Next-state and datapath control; every register holds by default.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        so_d    = so_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtract is a + ~b + 1; cin is ignored in that mode.
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                r_sh_d  = r_next;
                carry_d = nib_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Final slice: publish result, carry and signed overflow.
                    so_d    = r_next;
                    co_d    = nib_co;
                    ovf_d   = msb_cin ^ nib_co;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset drops any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            so_q    <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign so   = so_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (N=16) against an arithmetic model.
module tb_serial_add_ctrl;

    localparam int N = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] so;
    logic         co;
    logic         ovf;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] last_so = '0;

    serial_add_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .so    (so),
        .co    (co),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic. Returns {co, ovf, so}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic s, input logic ci);
        int unsigned ux, uy, ur;
        int          sx, sy, sr;
        logic [15:0] r;
        logic        c, v;
        ux = x; uy = y;
        sx = $signed(x); sy = $signed(y);
        if (s) begin
            ur = ux - uy;
            c  = (ux >= uy);
            sr = sx - sy;
        end else begin
            ur = ux + uy + int'(ci);
            c  = (ur > 32'h0000_FFFF);
            sr = sx + sy + int'(ci);
        end
        r = ur[15:0];
        v = (sr > 32767) || (sr < -32768);
        return {c, v, r};
    endfunction

    // Present an operation with start high; called at a falling edge.
    task automatic issue(input logic [15:0] x, input logic [15:0] y,
                         input logic s, input logic ci);
        a = x; b = y; sub = s; cin = ci; start = 1'b1;
    endtask

    // Follow one operation to its done pulse and check result and timing.
    task automatic wait_done(input logic [15:0] e_so, input logic e_co, input logic e_ovf,
                             input logic chk_hold, input logic [15:0] hold_so,
                             input logic inject, input string nm);
        int   cyc = 0;
        int   nbusy = 0;
        logic seen = 1'b0;
        logic hold_bad = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else begin
                if (busy) nbusy++;
                if (chk_hold && so !== hold_so) hold_bad = 1'b1;
            end
            if (inject && (cyc == 2 || cyc == 3)) begin
                start = 1'b1;
                a = 16'($urandom); b = 16'($urandom);
                sub = 1'($urandom); cin = 1'($urandom);
            end else if (!seen) begin
                start = 1'b0;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s done_timeout: no done within %0d cycles", nm, cyc);
        end
        n_vec++;
        if (cyc !== 5) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles, want 5", nm, cyc);
        end
        n_vec++;
        if (nbusy !== 4) begin
            n_err++;
            $display("FAIL %s busy_len: got %0d cycles, want 4", nm, nbusy);
        end
        n_vec++;
        if (so !== e_so) begin
            n_err++;
            $display("FAIL %s so: got %h, want %h", nm, so, e_so);
        end
        n_vec++;
        if (co !== e_co) begin
            n_err++;
            $display("FAIL %s co: got %b, want %b", nm, co, e_co);
        end
        n_vec++;
        if (ovf !== e_ovf) begin
            n_err++;
            $display("FAIL %s ovf: got %b, want %b", nm, ovf, e_ovf);
        end
        if (chk_hold) begin
            n_vec++;
            if (hold_bad) begin
                n_err++;
                $display("FAIL %s so_hold: so changed during RUN, want %h held", nm, hold_so);
            end
        end
        last_so = e_so;
    endtask

    // Check the block has gone quiet one cycle after done.
    task automatic check_idle(input string nm);
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_after_done: busy=%b done=%b, want 0 0", nm, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, co, ovf} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags: busy/done/co/ovf=%b, want 0000", {busy, done, co, ovf});
        end
        n_vec++;
        if (so !== 16'h0) begin
            n_err++;
            $display("FAIL reset_so: got %h, want 0000", so);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    typedef struct {
        logic [15:0] x, y;
        logic        s, ci;
        logic [15:0] so;
        logic        co, ovf;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[6];
        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].ci);
            wait_done(tbl[i].so, tbl[i].co, tbl[i].ovf, 1'b0, '0, 1'b0, $sformatf("dir%0d", i));
            check_idle($sformatf("dir%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(16'h8000, 1'b0, 1'b1, 1'b0, '0, 1'b0, "b2b_first");
        issue(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_done(16'h0002, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, "b2b_second");
        check_idle("b2b");
    endtask

    task automatic test_start_in_run();
        logic [17:0] m;
        m = model(16'h1234, 16'h0FF0, 1'b0, 1'b1);
        issue(16'h1234, 16'h0FF0, 1'b0, 1'b1);
        wait_done(m[15:0], m[17], m[16], 1'b0, '0, 1'b1, "start_in_run");
        check_idle("start_in_run");
    endtask

    task automatic test_reset_mid_run();
        int   dcnt = 0;
        logic [17:0] m;
        issue(16'hAAAA, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, done, co, ovf} !== 4'b0 || so !== 16'h0) begin
            n_err++;
            $display("FAIL midrun_reset: busy=%b done=%b so=%h co=%b ovf=%b, want all 0",
                     busy, done, so, co, ovf);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        n_vec++;
        if (dcnt !== 0) begin
            n_err++;
            $display("FAIL midrun_no_done: %0d cycles with busy/done, want 0", dcnt);
        end
        m = model(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
        issue(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
        wait_done(m[15:0], m[17], m[16], 1'b1, 16'h0000, 1'b0, "after_reset");
        check_idle("after_reset");
    endtask

    task automatic test_random();
        logic [17:0] m;
        logic [15:0] x, y;
        logic s, ci;
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom); y = 16'($urandom);
            s = 1'($urandom); ci = 1'($urandom);
            if (i % 8 == 0) y = x;
            m = model(x, y, s, ci);
            issue(x, y, s, ci);
            wait_done(m[15:0], m[17], m[16], 1'b1, last_so, 1'b0, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 0) begin
                start = 1'b0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_in_run();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
